// File: rtl/imm_packer_pkg.sv
// Shared CPU definitions: immediate formats, packer FSM states and the positions
// of the immediate fields inside an instruction word.
package imm_packer_pkg;

  typedef enum logic [1:0] {
    ZE5  = 2'd0,
    SE15 = 2'd1,
    ZE15 = 2'd2,
    SE20 = 2'd3
  } imm_fmt_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } pk_state_e;

  localparam int IMM5_LSB = 10;
  localparam int IMM5_W   = 5;
  localparam int IMM15_W  = 15;
  localparam int IMM20_W  = 20;

endpackage

// File: rtl/imm_insert.sv
// Inserts an immediate into an instruction word and flags values the format cannot
// represent; the inverse of the immediate-extension unit.
module imm_insert
  import imm_packer_pkg::*;
(
  input  imm_fmt_e    fmt,
  input  logic [31:0] base,
  input  logic [31:0] value,
  output logic [31:0] instr,
  output logic        misfit
);

  // Signed formats fit when every bit from the field's sign bit upward agrees.
  always_comb begin
    instr  = base;
    misfit = 1'b0;
    case (fmt)
      ZE5: begin
        instr[IMM5_LSB +: IMM5_W] = value[IMM5_W-1:0];
        misfit = |value[31:IMM5_W];
      end
      SE15: begin
        instr[IMM15_W-1:0] = value[IMM15_W-1:0];
        misfit = !((&value[31:IMM15_W-1]) || !(|value[31:IMM15_W-1]));
      end
      ZE15: begin
        instr[IMM15_W-1:0] = value[IMM15_W-1:0];
        misfit = |value[31:IMM15_W];
      end
      SE20: begin
        instr[IMM20_W-1:0] = value[IMM20_W-1:0];
        misfit = !((&value[31:IMM20_W-1]) || !(|value[31:IMM20_W-1]));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_packer.sv
// Load-session packer: takes len words, packs each immediate into its instruction
// word and presents it with an incrementing write address through one output register.
module imm_packer
  import imm_packer_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [31:0]       in_base,
  input  logic [31:0]       in_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              done,
  output logic [7:0]        err_cnt,
  output logic [1:0]        dbg_state
);

  // Handshakes: a word moves on a port in any cycle where valid && ready at the
  // rising edge; valid never waits on ready, and out_* hold while stalled.
  pk_state_e         state, state_nxt;
  logic [LEN_W-1:0]  cnt;
  logic [ADDR_W-1:0] nxt_addr;
  logic              start_acc, in_acc, out_acc;
  logic [31:0]       ins_instr;
  logic              ins_misfit;

  imm_insert u_insert (
    .fmt   (imm_fmt_e'(in_fmt)),
    .base  (in_base),
    .value (in_value),
    .instr (ins_instr),
    .misfit(ins_misfit)
  );

  assign start_acc = start && (state == IDLE);
  assign in_ready  = (state == RUN) && (!out_valid || out_ready);
  assign in_acc    = in_valid && in_ready;
  assign out_acc   = out_valid && out_ready;
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && (len != '0)) state_nxt = RUN;
      RUN:     if (in_acc && (cnt == LEN_W'(1))) state_nxt = FLUSH;
      FLUSH:   if (out_acc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      nxt_addr  <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_addr  <= '0;
      out_err   <= 1'b0;
      done      <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state <= state_nxt;
      done  <= (start_acc && (len == '0)) || ((state == FLUSH) && out_acc);

      // cnt holds the number of words still to be accepted in this session.
      if (start_acc) begin
        cnt      <= len;
        nxt_addr <= start_addr;
      end else if (in_acc) begin
        cnt      <= cnt - LEN_W'(1);
        nxt_addr <= nxt_addr + ADDR_W'(1);
      end

      if (in_acc) begin
        out_valid <= 1'b1;
        out_instr <= ins_instr;
        out_addr  <= nxt_addr;
        out_err   <= ins_misfit;
      end else if (out_acc) begin
        out_valid <= 1'b0;
      end

      if (start_acc)
        err_cnt <= '0;
      else if (out_acc && out_err && (err_cnt != 8'hFF))
        err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_imm_packer.sv
// Randomised scoreboard bench for imm_packer with directed session, backpressure,
// wrap, empty-session, saturation and mid-session reset cases.
module tb_imm_packer;
  import imm_packer_pkg::*;

  localparam int W = 78;  // {last, fmt, value, err, addr, instr}

  logic        clk, rst_n, start, in_valid, in_ready, out_valid, out_ready, out_err, done;
  logic [9:0]  start_addr, len, out_addr;
  logic [1:0]  in_fmt, dbg_state;
  logic [31:0] in_base, in_value, out_instr;
  logic [7:0]  err_cnt;

  logic [W-1:0] exp_q[$];
  logic [1:0]   w_fmt[$];
  logic [31:0]  w_base[$];
  logic [31:0]  w_value[$];

  int checks = 0, failures = 0;
  int cyc = 0, done_cnt = 0, sess_errs = 0, sess_first_cyc = 0, last_hs_cyc = 0;
  int rdy_mode = 0;
  logic        zero_start_now = 0, exp_done_nxt = 0;
  logic [31:0] last_instr;
  logic [9:0]  last_addr;
  logic        last_err;
  logic [7:0]  errcnt_at_done;
  int bnd[12] = '{31, 32, 16383, 16384, 32767, 32768, -16384, -16385,
                  524287, 524288, -524288, -524289};

  imm_packer #(.ADDR_W(10), .LEN_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_base(in_base),
    .in_value(in_value), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err), .done(done),
    .err_cnt(err_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [32:0] pack_model(input logic [1:0] f, input logic [31:0] b,
                                             input logic [31:0] v);
    longint sv, uv;
    int lsb, w;
    bit fits;
    logic [31:0] mask;
    sv = longint'($signed(v));
    uv = longint'(v);
    lsb = 0;
    case (f)
      2'd0:    begin w = 5;  lsb = 10; fits = (uv < 32); end
      2'd1:    begin w = 15; fits = (sv >= -16384) && (sv <= 16383); end
      2'd2:    begin w = 15; fits = (uv < 32768); end
      default: begin w = 20; fits = (sv >= -524288) && (sv <= 524287); end
    endcase
    mask = 32'(((64'd1 << w) - 64'd1) << lsb);
    return {!fits, (b & ~mask) | ((v << lsb) & mask)};
  endfunction

  function automatic logic [31:0] ext_model(input logic [1:0] f, input logic [31:0] ins);
    logic [31:0] fld;
    case (f)
      2'd0: return (ins >> 10) & 32'h1F;
      2'd1: begin
        fld = ins & 32'h7FFF;
        return (fld >= 32'h4000) ? fld - 32'h8000 : fld;
      end
      2'd2: return ins & 32'h7FFF;
      default: begin
        fld = ins & 32'hFFFFF;
        return (fld >= 32'h80000) ? fld - 32'h100000 : fld;
      end
    endcase
  endfunction

  function automatic logic [31:0] rand_value();
    case ($urandom_range(0, 4))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 31));
      2:       return 32'($urandom_range(0, 32'h7FFF));
      3:       return 32'(-int'($urandom_range(1, 32'h80000)));
      default: return 32'(bnd[$urandom_range(0, 11)]);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
      else if (rdy_mode == 0) out_ready = 1'b1;
    end
  end

  task automatic feed_word(input logic [1:0] f, input logic [31:0] b, input logic [31:0] v,
                           input logic [9:0] a, input logic last, output int acc_cyc);
    logic [32:0] m;
    bit acc;
    int guard;
    acc = 0;
    guard = 0;
    acc_cyc = 0;
    in_valid = 1'b1; in_fmt = f; in_base = b; in_value = v;
    while (!acc && guard < 500) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        acc_cyc = cyc;
        m = pack_model(f, b, v);
        sess_errs += int'(m[32]);
        exp_q.push_back({last, f, v, m[32], a, m[31:0]});
      end
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    if (!acc) chk("in_accept_timeout", 0, 1);
  endtask

  task automatic run_session(input logic [9:0] a, input int n, input bit gaps);
    int dc0, guard, c;
    bit seen;
    logic [9:0] addr;
    dc0 = done_cnt;
    sess_errs = 0;
    start = 1'b1; start_addr = a; len = 10'(n); zero_start_now = (n == 0);
    @(posedge clk);
    #1;
    start = 1'b0; zero_start_now = 1'b0;
    addr = a;
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      feed_word(w_fmt[i], w_base[i], w_value[i], addr, (i == n - 1), c);
      if (i == 0) sess_first_cyc = c;
      addr = addr + 10'd1;
    end
    seen = 0;
    guard = 0;
    while (!seen && guard < 200) begin
      @(negedge clk);
      guard++;
      if (done) begin
        seen = 1;
        errcnt_at_done = err_cnt;
      end
    end
    @(posedge clk);
    #1;
    chk("done_seen", seen, 1);
    chk("done_count", done_cnt - dc0, 1);
    chk("err_cnt_at_done", errcnt_at_done, (sess_errs > 255) ? 255 : sess_errs);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic clear_words();
    w_fmt.delete(); w_base.delete(); w_value.delete();
  endtask

  task automatic add_word(input logic [1:0] f, input logic [31:0] b, input logic [31:0] v);
    w_fmt.push_back(f); w_base.push_back(b); w_value.push_back(v);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W-1:0] e;
    logic [44:0]  prev_out;
    bit prev_stall, have_prev;
    prev_stall = 0; have_prev = 0; prev_out = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_done_nxt = 0;
        have_prev = 0;
      end else begin
        chk("done_pulse", done, exp_done_nxt);
        if (done) done_cnt++;
        exp_done_nxt = zero_start_now;
        if (have_prev && prev_stall)
          chk("stall_stable", {out_valid, out_instr, out_addr, out_err}, prev_out);
        if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
        prev_stall = out_valid && !out_ready;
        prev_out = {out_valid, out_instr, out_addr, out_err};
        have_prev = 1;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("out_instr", out_instr, e[31:0]);
            chk("out_addr", out_addr, e[41:32]);
            chk("out_err", out_err, e[42]);
            if (!e[42]) chk("roundtrip", ext_model(e[76:75], out_instr), e[74:43]);
            if (e[77]) begin
              exp_done_nxt = 1;
              last_hs_cyc = cyc;
            end
            last_instr = out_instr; last_addr = out_addr; last_err = out_err;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int total, n, c, dc0;
    rst_n = 1'b0; start = 1'b0; start_addr = '0; len = '0;
    in_valid = 1'b0; in_fmt = '0; in_base = '0; in_value = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_done", done, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_state", dbg_state, IDLE);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", in_ready, 0);

    // single SE15 word
    clear_words();
    add_word(SE15, 32'hA5A50000, 32'hFFFFC000);
    run_session(10'h010, 1, 0);
    chk("se15_instr", last_instr, 32'hA5A54000);
    chk("se15_addr", last_addr, 10'h010);
    chk("se15_err", last_err, 0);

    // ZE5 misfit
    clear_words();
    add_word(ZE5, 32'hFFFFFFFF, 32'h20);
    run_session(10'h123, 1, 0);
    chk("ze5_err", last_err, 1);
    chk("ze5_field", last_instr[14:10], 0);
    chk("ze5_err_cnt", errcnt_at_done, 1);

    // address wrap at full throughput
    clear_words();
    for (int i = 0; i < 3; i++) add_word(2'($urandom_range(0, 3)), $urandom, rand_value());
    run_session(10'h3FF, 3, 0);
    chk("wrap_last_addr", last_addr, 10'h001);
    chk("throughput", last_hs_cyc - sess_first_cyc, 3);

    // empty session
    run_session(10'h055, 0, 0);

    // mid-stream stall plus an ignored start
    clear_words();
    for (int i = 0; i < 10; i++) add_word(2'($urandom_range(0, 3)), $urandom, rand_value());
    rdy_mode = 2;
    out_ready = 1'b1;
    fork
      run_session(10'h200, 10, 0);
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
        start = 1'b1; start_addr = 10'h2AA; len = 10'd7;
        @(posedge clk);
        #1 start = 1'b0;
      end
    join
    rdy_mode = 0;

    // err_cnt saturation
    clear_words();
    for (int i = 0; i < 260; i++) add_word(ZE5, $urandom, 32'($urandom_range(32, 32'hFFFF)));
    run_session(10'h300, 260, 0);

    // random sessions
    total = 0;
    rdy_mode = 1;
    while (total < 1000) begin
      n = $urandom_range(1, 40);
      clear_words();
      for (int i = 0; i < n; i++) add_word(2'($urandom_range(0, 3)), $urandom, rand_value());
      run_session(10'($urandom_range(0, 1023)), n, 1'($urandom_range(0, 1)));
      total += n;
    end

    // reset in RUN with a word held in the output register
    rdy_mode = 2;
    out_ready = 1'b0;
    dc0 = done_cnt;
    start = 1'b1; start_addr = 10'h100; len = 10'd5;
    @(posedge clk);
    #1 start = 1'b0;
    feed_word(SE20, $urandom, 32'h123, 10'h100, 1'b0, c);
    chk("rst_pre_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_instr", out_instr, 0);
    chk("arst_out_addr", out_addr, 0);
    chk("arst_out_err", out_err, 0);
    chk("arst_done", done, 0);
    chk("arst_err_cnt", err_cnt, 0);
    chk("arst_in_ready", in_ready, 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    rdy_mode = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_no_done", done_cnt - dc0, 0);
    chk("rst_no_output", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
